// File: rtl/traffic_pkg.sv
// Shared constants and types for the traffic-light controller blocks.
// Interval slot addresses, default durations and the timer state encoding.
package traffic_pkg;

  localparam logic [1:0] ADDR_BASE = 2'b00;
  localparam logic [1:0] ADDR_EXT  = 2'b01;
  localparam logic [1:0] ADDR_YEL  = 2'b10;

  localparam int T_BASE_DEFAULT = 6;
  localparam int T_EXT_DEFAULT  = 3;
  localparam int T_YEL_DEFAULT  = 2;
  localparam int NUM_SLOTS      = 3;

  typedef enum logic {
    IDLE,
    COUNT
  } timer_state_t;

  // Address 11 has no slot of its own and reads the base interval.
  function automatic logic [1:0] slot_index(input logic [1:0] addr);
    return (addr == ADDR_EXT || addr == ADDR_YEL) ? addr : ADDR_BASE;
  endfunction

endpackage

// File: rtl/interval_timer_if.sv
// Request/program/status bundle between the traffic FSM (master) and the
// interval timer (slave).
interface interval_timer_if;

  logic       start_timer;
  logic [1:0] interval_address;
  logic       prg_sync_in;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       expired;
  logic       one_hz_tick;
  logic [3:0] seconds_left;

  modport master (
    output start_timer, interval_address, prg_sync_in, time_param_sel, time_value,
    input  expired, one_hz_tick, seconds_left
  );

  modport slave (
    input  start_timer, interval_address, prg_sync_in, time_param_sel, time_value,
    output expired, one_hz_tick, seconds_left
  );

endinterface

// File: rtl/one_hz_divider.sv
// Prescaler counting 0..TICK_DIV-1; tick is high for the terminal count.
// clear restarts the count so the next second is full length.
module one_hz_divider #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic sys_reset,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W   = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (sys_reset || clear) begin
      r_count <= '0;
    end else if (r_count == CNT_MAX) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign tick = (r_count == CNT_MAX);

endmodule

// File: rtl/interval_timer.sv
// Programmable countdown timer: three writable interval slots, a one-second
// prescaler and an IDLE/COUNT FSM that emits a one-cycle expired pulse.
module interval_timer
  import traffic_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int T_BASE_DEF = T_BASE_DEFAULT,
  parameter int T_EXT_DEF  = T_EXT_DEFAULT,
  parameter int T_YEL_DEF  = T_YEL_DEFAULT
) (
  input  logic             clk,
  input  logic             sys_reset,
  interval_timer_if.slave  bus
);

  localparam logic [NUM_SLOTS-1:0][3:0] SLOT_DEF =
    {4'(T_YEL_DEF), 4'(T_EXT_DEF), 4'(T_BASE_DEF)};

  logic [NUM_SLOTS-1:0][3:0] w_slot;
  logic                      w_tick;
  logic                      w_presc_clear;
  logic [3:0]                w_load_value;

  timer_state_t r_state;
  logic [3:0]   r_seconds_left;
  logic         r_expired;

  // Zero-second writes are dropped so a slot can never hold an empty interval.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    logic [3:0] r_value;
    logic       w_we;

    assign w_we = bus.prg_sync_in && (bus.time_value != 4'd0) &&
                  (bus.time_param_sel == 2'(gi));

    always_ff @(posedge clk) begin
      if (sys_reset) begin
        r_value <= SLOT_DEF[gi];
      end else if (w_we) begin
        r_value <= bus.time_value;
      end
    end

    assign w_slot[gi] = r_value;
  end

  assign w_presc_clear = bus.start_timer && !bus.prg_sync_in;
  assign w_load_value  = w_slot[slot_index(bus.interval_address)];

  one_hz_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_divider (
    .clk       (clk),
    .sys_reset (sys_reset),
    .clear     (w_presc_clear),
    .tick      (w_tick)
  );

  // Reprogramming aborts silently; a reload wins over the terminal tick.
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      r_state        <= IDLE;
      r_seconds_left <= 4'd0;
      r_expired      <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      if (bus.prg_sync_in) begin
        r_state        <= IDLE;
        r_seconds_left <= 4'd0;
      end else if (bus.start_timer) begin
        r_state        <= COUNT;
        r_seconds_left <= w_load_value;
      end else if (r_state == COUNT && w_tick) begin
        if (r_seconds_left > 4'd1) begin
          r_seconds_left <= r_seconds_left - 4'd1;
        end else begin
          r_seconds_left <= 4'd0;
          r_expired      <= 1'b1;
          r_state        <= IDLE;
        end
      end
    end
  end

  assign bus.expired      = r_expired;
  assign bus.seconds_left = r_seconds_left;
  assign bus.one_hz_tick  = w_tick;

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer with TICK_DIV=4; expired pulses are logged
// by edge number and compared against hand-computed edges.
module tb_interval_timer;

  localparam int TICK_DIV = 4;

  logic clk = 1'b0;
  logic sys_reset;
  int   edge_n   = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_q[$];

  interval_timer_if bus ();

  interval_timer #(
    .TICK_DIV   (TICK_DIV),
    .T_BASE_DEF (6),
    .T_EXT_DEF  (3),
    .T_YEL_DEF  (2)
  ) dut (
    .clk       (clk),
    .sys_reset (sys_reset),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // An entry e means expired was high in the cycle after edge e.
  always @(negedge clk) if (bus.expired === 1'b1) exp_q.push_back(edge_n);

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one cycle of request/program inputs; k is the edge that sampled them.
  task automatic pulse(input logic st, input logic [1:0] addr, input logic prg,
                       input logic [1:0] sel, input logic [3:0] val, output int k);
    bus.start_timer      = st;
    bus.interval_address = addr;
    bus.prg_sync_in      = prg;
    bus.time_param_sel   = sel;
    bus.time_value       = val;
    @(posedge clk);
    #1;
    k = edge_n;
    bus.start_timer = 1'b0;
    bus.prg_sync_in = 1'b0;
  endtask

  task automatic check_expired(input string tag, input int first, input int n, input int step);
    chk({tag, "_count"}, exp_q.size(), n);
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk($sformatf("%s_at%0d", tag, i), exp_q[i], first + i * step);
    exp_q.delete();
  endtask

  initial begin
    int k;
    int k2;
    int seen;

    bus.start_timer      = 1'b0;
    bus.interval_address = 2'b00;
    bus.prg_sync_in      = 1'b0;
    bus.time_param_sel   = 2'b00;
    bus.time_value       = 4'd0;
    sys_reset            = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seconds", bus.seconds_left, 0);
    chk("rst_expired", bus.expired, 0);
    chk("rst_tick", bus.one_hz_tick, 0);
    sys_reset = 1'b0;
    wait_edges(2);

    // 1: base interval of 6 s
    exp_q.delete();
    pulse(1'b1, 2'b00, 1'b0, 2'b00, 4'd0, k);
    chk("s1_load", bus.seconds_left, 6);
    wait_edges(2);
    chk("s1_tick_lo", bus.one_hz_tick, 0);
    wait_edges(1);
    chk("s1_tick_hi", bus.one_hz_tick, 1);
    wait_edges(1);
    chk("s1_dec", bus.seconds_left, 5);
    wait_to(k + 27);
    chk("s1_done", bus.seconds_left, 0);
    check_expired("s1_exp", k + 24, 1, 0);

    // 2: program yellow to 5, then ignored writes
    pulse(1'b0, 2'b00, 1'b1, 2'b10, 4'd5, k);
    pulse(1'b1, 2'b10, 1'b0, 2'b00, 4'd0, k);
    chk("s2_load", bus.seconds_left, 5);
    wait_to(k + 23);
    check_expired("s2_exp", k + 20, 1, 0);
    pulse(1'b0, 2'b00, 1'b1, 2'b10, 4'd0, k);
    pulse(1'b0, 2'b00, 1'b1, 2'b11, 4'd9, k);
    pulse(1'b1, 2'b10, 1'b0, 2'b00, 4'd0, k);
    chk("s2_keep", bus.seconds_left, 5);
    wait_to(k + 23);
    check_expired("s2_exp2", k + 20, 1, 0);
    pulse(1'b1, 2'b11, 1'b0, 2'b00, 4'd0, k);
    chk("s2_alias", bus.seconds_left, 6);

    // 3: reload four cycles before the terminal tick
    pulse(1'b1, 2'b00, 1'b0, 2'b00, 4'd0, k);
    exp_q.delete();
    wait_to(k + 19);
    pulse(1'b1, 2'b00, 1'b0, 2'b00, 4'd0, k2);
    chk("s3_reload", bus.seconds_left, 6);
    wait_to(k2 + 27);
    check_expired("s3_exp", k2 + 24, 1, 0);

    // 4: program strobe with simultaneous start aborts the count
    pulse(1'b1, 2'b00, 1'b0, 2'b00, 4'd0, k);
    wait_to(k + 10);
    pulse(1'b1, 2'b01, 1'b1, 2'b00, 4'd0, k2);
    chk("s4_abort", bus.seconds_left, 0);
    wait_edges(40);
    chk("s4_hold", bus.seconds_left, 0);
    check_expired("s4_none", 0, 0, 0);

    // 5: reset mid-count restores defaults
    pulse(1'b0, 2'b00, 1'b1, 2'b01, 4'd9, k);
    pulse(1'b1, 2'b01, 1'b0, 2'b00, 4'd0, k);
    chk("s5_load9", bus.seconds_left, 9);
    wait_edges(6);
    sys_reset = 1'b1;
    @(posedge clk);
    #1;
    sys_reset = 1'b0;
    chk("s5_rst_seconds", bus.seconds_left, 0);
    chk("s5_rst_expired", bus.expired, 0);
    chk("s5_rst_tick", bus.one_hz_tick, 0);
    wait_edges(40);
    check_expired("s5_none", 0, 0, 0);
    pulse(1'b1, 2'b01, 1'b0, 2'b00, 4'd0, k);
    chk("s5_ext_def", bus.seconds_left, 3);
    wait_to(k + 15);
    check_expired("s5_ext_exp", k + 12, 1, 0);
    pulse(1'b1, 2'b11, 1'b0, 2'b00, 4'd0, k);
    chk("s5_alias", bus.seconds_left, 6);
    wait_to(k + 27);
    check_expired("s5_alias_exp", k + 24, 1, 0);

    // 6: back-to-back yellow, restarting on each expired pulse
    pulse(1'b1, 2'b10, 1'b0, 2'b00, 4'd0, k);
    chk("s6_load", bus.seconds_left, 2);
    for (int i = 0; i < 3; i++) begin
      seen = 0;
      for (int c = 0; c < 40 && seen == 0; c++) begin
        wait_edges(1);
        if (bus.expired === 1'b1) seen = 1;
      end
      chk($sformatf("s6_seen%0d", i), seen, 1);
      if (seen == 1) pulse(1'b1, 2'b10, 1'b0, 2'b00, 4'd0, k2);
    end
    wait_edges(15);
    check_expired("s6_exp", k + 8, 4, 9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/interval_timer.md
# interval_timer

Programmable countdown timer that sits between the traffic-light FSM and the clock. It consumes the FSM's `start_timer` / `interval_address` request, counts the selected interval in whole seconds, and returns a one-cycle `expired` pulse. It also holds the three programmable time parameters (base, extended, yellow), and the reprogramming path writes new values into them.

## Interface
Parameters:
- `TICK_DIV`, default 100_000_000: clock cycles per second tick, minimum 2. Benches use 4.
- `T_BASE_DEF`, default 6: reset value of interval slot 0, in seconds.
- `T_EXT_DEF`, default 3: reset value of interval slot 1.
- `T_YEL_DEF`, default 2: reset value of interval slot 2.

Ports:
- `clk` in 1: single system clock, rising edge.
- `sys_reset` in 1: synchronous, active-high reset.
- `start_timer` in 1: one-cycle load request from the FSM.
- `interval_address` in 2: selects the slot to load. 00 = base, 01 = extended, 10 = yellow, 11 = aliased to base.
- `prg_sync_in` in 1: synchronized one-cycle reprogram strobe.
- `time_param_sel` in 2: slot to write on `prg_sync_in`.
- `time_value` in 4: seconds to write, range 1..15.
- `expired` out 1: one-cycle pulse when the countdown completes.
- `one_hz_tick` out 1: prescaler tick, for debug and the display.
- `seconds_left` out 4: current countdown value.

## Operation
- Slot registers:
  - Three 4-bit registers hold the intervals.
  - `sys_reset` loads the `*_DEF` values.
  - On `prg_sync_in`, `time_value` is written to slot `time_param_sel`.
  - A write with `time_value` == 0 is ignored; the slot keeps its value.
  - A write with `time_param_sel` == 11 is ignored.
- Prescaler: counter 0..TICK_DIV-1. `one_hz_tick` is high while the count equals TICK_DIV-1, then the counter wraps to 0. It clears to 0 on `start_timer` so the first second is full length.
- States: IDLE, COUNT.
  - Any state, `start_timer`: `seconds_left` ← slot[`interval_address`], prescaler ← 0, go to COUNT.
  - COUNT with tick and `seconds_left` > 1: decrement.
  - COUNT with tick and `seconds_left` == 1: `seconds_left` ← 0, `expired` ← 1 for the next cycle, go to IDLE.
  - IDLE: hold. Ticks are ignored.
- Priorities, highest first:
  1. `sys_reset`
  2. `prg_sync_in`: aborts any countdown, goes to IDLE, `seconds_left` ← 0, no `expired`, any `start_timer` in the same cycle is dropped.
  3. `start_timer`: reloads even on the terminal-tick cycle, so `expired` is suppressed.
  4. Tick.
- Arithmetic is unsigned 4-bit. `seconds_left` never wraps below 0.

## Timing
- Reset values: `expired`=0, `one_hz_tick`=0, `seconds_left`=0, state IDLE, prescaler 0, slots = defaults.
- `start_timer` sampled at edge k with slot value N ⇒ `expired` is high for exactly the cycle after edge k+N·TICK_DIV.
- `seconds_left` decrements at edges k+TICK_DIV, k+2·TICK_DIV, and so on.
- `expired` is registered and never high for two consecutive cycles.
- A slot write at edge k is visible to a `start_timer` sampled at edge k+1 or later.
- `sys_reset` asserted mid-count: the countdown is abandoned, no `expired` is produced, and programmed slots revert to defaults.

## Structure
- Shared package `traffic_pkg` holds:
  - Interval address constants `ADDR_BASE`=2'b00, `ADDR_EXT`=2'b01, `ADDR_YEL`=2'b10.
  - Default time constants.
  - Timer state enum {IDLE, COUNT}.
- Sub-module `one_hz_divider`: parameter `TICK_DIV`; ports `clk`, `sys_reset`, `clear`; output `tick`.
- Top: slot register file, countdown FSM, output registers.

## Test plan
All scenarios use TICK_DIV=4.
1. Reset, then `start_timer` at edge 10 with address 00 → `seconds_left`=6, `expired` high only in the cycle after edge 34.
2. `prg_sync_in` with sel=10, value=5, then start with address 10 → `expired` after 20 cycles. Then write value=0 to slot 10 → slot stays 5.
3. `start_timer` re-asserted at edge 30 of a 6 s base count → reload to 6, no `expired` at 34, `expired` after edge 54.
4. `prg_sync_in` and `start_timer` in the same cycle while counting → IDLE, `seconds_left`=0, no `expired` ever.
5. `sys_reset` mid-count after reprogramming slot 01 to 9 → all outputs 0. Next start with address 01 counts the default 3 (`expired` after 12 cycles). Address 11 counts 6.
6. Back-to-back yellow intervals, FSM restarting on each `expired` → `expired` every 8+1 cycles, each pulse exactly 1 cycle wide.
